etapa_execute: RTL and testbench

- Execute (EX) stage of the 5-stage MIPS pipeline.
- Consumes the forwarding selects from unidad_cortocircuito and applies them to the rs/rt operands, then runs the ALU.
- Picks the destination register and registers everything into the EX/MEM pipeline latch.
- The latch outputs feed the MEM stage. o_alu_result_MEM and the write-back data from WB are also the forwarding sources for the next instruction.

---
 rtl/etapa_execute.sv | 148 ++++++++++++++
 tb/tb_etapa_execute.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/etapa_execute.sv
// Execute stage: operand forwarding, ALU, destination select and EX/MEM latch.
module etapa_execute #(
  parameter int unsigned NB_DATA   = 32,
  parameter int unsigned NB_REG    = 5,
  parameter int unsigned NB_ALU_OP = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_enable,
  input  logic                 i_flush,
  input  logic [NB_DATA-1:0]   i_rs_data,
  input  logic [NB_DATA-1:0]   i_rt_data,
  input  logic [NB_DATA-1:0]   i_imm,
  input  logic [4:0]           i_shamt,
  input  logic [NB_DATA-1:0]   i_pc_plus4,
  input  logic [NB_REG-1:0]    i_rt,
  input  logic [NB_REG-1:0]    i_rd,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic                 i_alu_src,
  input  logic [1:0]           i_reg_dst,
  input  logic                 i_link,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  input  logic                 i_mem_to_reg,
  input  logic                 i_write_reg,
  input  logic [1:0]           i_corto_rs,
  input  logic [1:0]           i_corto_rt,
  input  logic [NB_DATA-1:0]   i_wb_data,
  output logic [NB_DATA-1:0]   o_alu_result_MEM,
  output logic [NB_DATA-1:0]   o_store_data_MEM,
  output logic [NB_REG-1:0]    o_rd_MEM,
  output logic                 o_mem_read_MEM,
  output logic                 o_mem_write_MEM,
  output logic                 o_mem_to_reg_MEM,
  output logic                 o_write_reg_MEM
);

  localparam int unsigned NB_HALF = NB_DATA / 2;

  localparam logic [NB_ALU_OP-1:0] OP_ADD  = NB_ALU_OP'(4'b0000);
  localparam logic [NB_ALU_OP-1:0] OP_SUB  = NB_ALU_OP'(4'b0001);
  localparam logic [NB_ALU_OP-1:0] OP_AND  = NB_ALU_OP'(4'b0010);
  localparam logic [NB_ALU_OP-1:0] OP_OR   = NB_ALU_OP'(4'b0011);
  localparam logic [NB_ALU_OP-1:0] OP_XOR  = NB_ALU_OP'(4'b0100);
  localparam logic [NB_ALU_OP-1:0] OP_NOR  = NB_ALU_OP'(4'b0101);
  localparam logic [NB_ALU_OP-1:0] OP_SLT  = NB_ALU_OP'(4'b0110);
  localparam logic [NB_ALU_OP-1:0] OP_SLTU = NB_ALU_OP'(4'b0111);
  localparam logic [NB_ALU_OP-1:0] OP_SLL  = NB_ALU_OP'(4'b1000);
  localparam logic [NB_ALU_OP-1:0] OP_SRL  = NB_ALU_OP'(4'b1001);
  localparam logic [NB_ALU_OP-1:0] OP_SRA  = NB_ALU_OP'(4'b1010);
  localparam logic [NB_ALU_OP-1:0] OP_SLLV = NB_ALU_OP'(4'b1011);
  localparam logic [NB_ALU_OP-1:0] OP_SRLV = NB_ALU_OP'(4'b1100);
  localparam logic [NB_ALU_OP-1:0] OP_SRAV = NB_ALU_OP'(4'b1101);
  localparam logic [NB_ALU_OP-1:0] OP_LUI  = NB_ALU_OP'(4'b1110);

  logic [NB_DATA-1:0] op_a;
  logic [NB_DATA-1:0] fwd_b;
  logic [NB_DATA-1:0] op_b;
  logic [NB_DATA-1:0] alu_out;
  logic [NB_DATA-1:0] result;
  logic [NB_REG-1:0]  dest;
  logic [4:0]         var_shamt;

  // Forwarding muxes: MEM latch has priority over WB; select 11 falls back to register value.
  always_comb begin
    op_a  = i_rs_data;
    fwd_b = i_rt_data;
    case (i_corto_rs)
      2'b10:   op_a = o_alu_result_MEM;
      2'b01:   op_a = i_wb_data;
      default: op_a = i_rs_data;
    endcase
    case (i_corto_rt)
      2'b10:   fwd_b = o_alu_result_MEM;
      2'b01:   fwd_b = i_wb_data;
      default: fwd_b = i_rt_data;
    endcase
    op_b = i_alu_src ? i_imm : fwd_b;
  end

  assign var_shamt = op_a[4:0];

  // ALU; arithmetic wraps, unused code yields zero.
  always_comb begin
    alu_out = '0;
    case (i_alu_op)
      OP_ADD:  alu_out = op_a + op_b;
      OP_SUB:  alu_out = op_a - op_b;
      OP_AND:  alu_out = op_a & op_b;
      OP_OR:   alu_out = op_a | op_b;
      OP_XOR:  alu_out = op_a ^ op_b;
      OP_NOR:  alu_out = ~(op_a | op_b);
      OP_SLT:  alu_out = NB_DATA'($signed(op_a) < $signed(op_b));
      OP_SLTU: alu_out = NB_DATA'(op_a < op_b);
      OP_SLL:  alu_out = op_b << i_shamt;
      OP_SRL:  alu_out = op_b >> i_shamt;
      OP_SRA:  alu_out = NB_DATA'($signed(op_b) >>> i_shamt);
      OP_SLLV: alu_out = op_b << var_shamt;
      OP_SRLV: alu_out = op_b >> var_shamt;
      OP_SRAV: alu_out = NB_DATA'($signed(op_b) >>> var_shamt);
      OP_LUI:  alu_out = {op_b[NB_HALF-1:0], {(NB_DATA-NB_HALF){1'b0}}};
      default: alu_out = '0;
    endcase
  end

  // Link override and destination register select.
  always_comb begin
    result = i_link ? (i_pc_plus4 + NB_DATA'(4)) : alu_out;
    dest   = i_rt;
    case (i_reg_dst)
      2'b01:   dest = i_rd;
      2'b10:   dest = NB_REG'(31);
      default: dest = i_rt;
    endcase
  end

  // EX/MEM latch: hold on stall (even if flushing), bubble on flush, else load.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_alu_result_MEM <= '0;
      o_store_data_MEM <= '0;
      o_rd_MEM         <= '0;
      o_mem_read_MEM   <= 1'b0;
      o_mem_write_MEM  <= 1'b0;
      o_mem_to_reg_MEM <= 1'b0;
      o_write_reg_MEM  <= 1'b0;
    end else if (i_enable) begin
      if (i_flush) begin
        o_alu_result_MEM <= '0;
        o_store_data_MEM <= '0;
        o_rd_MEM         <= '0;
        o_mem_read_MEM   <= 1'b0;
        o_mem_write_MEM  <= 1'b0;
        o_mem_to_reg_MEM <= 1'b0;
        o_write_reg_MEM  <= 1'b0;
      end else begin
        o_alu_result_MEM <= result;
        o_store_data_MEM <= fwd_b;
        o_rd_MEM         <= dest;
        o_mem_read_MEM   <= i_mem_read;
        o_mem_write_MEM  <= i_mem_write;
        o_mem_to_reg_MEM <= i_mem_to_reg;
        o_write_reg_MEM  <= i_write_reg;
      end
    end
  end

endmodule

// File: tb/tb_etapa_execute.sv
// Directed bench for the execute stage with hand-computed expectations.
module tb_etapa_execute;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        flush;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;
  logic [4:0]  shamt;
  logic [31:0] pc_plus4;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic [1:0]  reg_dst;
  logic        link;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        write_reg;
  logic [1:0]  corto_rs;
  logic [1:0]  corto_rt;
  logic [31:0] wb_data;
  logic [31:0] alu_result_mem;
  logic [31:0] store_data_mem;
  logic [4:0]  rd_mem;
  logic        mem_read_mem;
  logic        mem_write_mem;
  logic        mem_to_reg_mem;
  logic        write_reg_mem;

  int checks;
  int failures;

  etapa_execute dut (
    .i_clk            (clk),
    .i_reset_n        (rst_n),
    .i_enable         (enable),
    .i_flush          (flush),
    .i_rs_data        (rs_data),
    .i_rt_data        (rt_data),
    .i_imm            (imm),
    .i_shamt          (shamt),
    .i_pc_plus4       (pc_plus4),
    .i_rt             (rt),
    .i_rd             (rd),
    .i_alu_op         (alu_op),
    .i_alu_src        (alu_src),
    .i_reg_dst        (reg_dst),
    .i_link           (link),
    .i_mem_read       (mem_read),
    .i_mem_write      (mem_write),
    .i_mem_to_reg     (mem_to_reg),
    .i_write_reg      (write_reg),
    .i_corto_rs       (corto_rs),
    .i_corto_rt       (corto_rt),
    .i_wb_data        (wb_data),
    .o_alu_result_MEM (alu_result_mem),
    .o_store_data_MEM (store_data_mem),
    .o_rd_MEM         (rd_mem),
    .o_mem_read_MEM   (mem_read_mem),
    .o_mem_write_MEM  (mem_write_mem),
    .o_mem_to_reg_MEM (mem_to_reg_mem),
    .o_write_reg_MEM  (write_reg_mem)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    enable = 1'b1; flush = 1'b0;
    rs_data = '0; rt_data = '0; imm = '0; shamt = '0; pc_plus4 = '0;
    rt = '0; rd = '0; alu_op = '0; alu_src = 1'b0; reg_dst = 2'b00; link = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; write_reg = 1'b0;
    corto_rs = 2'b00; corto_rt = 2'b00; wb_data = '0;
  endtask

  // Advance one rising edge, then settle on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_res"},  alu_result_mem, 32'h0);
    check({tag, "_st"},   store_data_mem, 32'h0);
    check({tag, "_rd"},   32'(rd_mem), 32'h0);
    check({tag, "_ctrl"}, 32'({mem_read_mem, mem_write_mem, mem_to_reg_mem, write_reg_mem}), 32'h0);
  endtask

  // ALU table: fixed A/B, shamt=4, A[4:0]=4.
  logic [3:0]  tbl_op  [11];
  logic [31:0] tbl_exp [11];

  initial begin
    checks = 0;
    failures = 0;
    tbl_op[0]  = 4'b0001; tbl_exp[0]  = 32'h8F0F0E34;
    tbl_op[1]  = 4'b0010; tbl_exp[1]  = 32'h00000020;
    tbl_op[2]  = 4'b0011; tbl_exp[2]  = 32'h8F0F0FF4;
    tbl_op[3]  = 4'b0100; tbl_exp[3]  = 32'h8F0F0FD4;
    tbl_op[4]  = 4'b0101; tbl_exp[4]  = 32'h70F0F00B;
    tbl_op[5]  = 4'b1000; tbl_exp[5]  = 32'h00000F00;
    tbl_op[6]  = 4'b1001; tbl_exp[6]  = 32'h0800000F;
    tbl_op[7]  = 4'b1011; tbl_exp[7]  = 32'h00000F00;
    tbl_op[8]  = 4'b1100; tbl_exp[8]  = 32'h0800000F;
    tbl_op[9]  = 4'b1101; tbl_exp[9]  = 32'hF800000F;
    tbl_op[10] = 4'b1111; tbl_exp[10] = 32'h00000000;

    // Reset held with live inputs
    clear_inputs();
    rst_n = 1'b0;
    rs_data = 32'd5; rt_data = 32'd7; rd = 5'd9; reg_dst = 2'b01;
    write_reg = 1'b1; mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1;
    step();
    step();
    check_all_zero("reset_hold");
    clear_inputs();
    rst_n = 1'b1;

    // ADD, no forwarding
    rs_data = 32'd5; rt_data = 32'd7; alu_op = 4'b0000; reg_dst = 2'b01; rd = 5'd9; write_reg = 1'b1;
    step();
    check("add_res", alu_result_mem, 32'd12);
    check("add_rd", 32'(rd_mem), 32'd9);
    check("add_wr", 32'(write_reg_mem), 32'd1);

    // SUB with rs forwarded from MEM latch (12)
    rs_data = 32'd0; corto_rs = 2'b10; rt_data = 32'd3; alu_op = 4'b0001;
    step();
    check("fwd_mem_sub", alu_result_mem, 32'd9);

    // ADD with rt forwarded from WB
    corto_rs = 2'b00; corto_rt = 2'b01; wb_data = 32'd100; alu_src = 1'b0; rs_data = 32'd1; alu_op = 4'b0000;
    step();
    check("fwd_wb_add", alu_result_mem, 32'd101);
    check("fwd_wb_st", store_data_mem, 32'd100);

    // Store: immediate into ALU, forwarded rt into store data
    alu_src = 1'b1; imm = 32'd4; corto_rt = 2'b01; wb_data = 32'h0000DEAD; mem_write = 1'b1; write_reg = 1'b0;
    rs_data = 32'd1;
    step();
    check("store_res", alu_result_mem, 32'd5);
    check("store_data", store_data_mem, 32'h0000DEAD);
    check("store_mw", 32'(mem_write_mem), 32'd1);
    check("store_wr", 32'(write_reg_mem), 32'd0);

    // Select 11 behaves as no forwarding; reg_dst 11 picks rt
    clear_inputs();
    rs_data = 32'd2; rt_data = 32'd3; corto_rs = 2'b11; corto_rt = 2'b11; wb_data = 32'd1000;
    reg_dst = 2'b11; rt = 5'd4; rd = 5'd9; mem_read = 1'b1; mem_to_reg = 1'b1;
    step();
    check("corto11_res", alu_result_mem, 32'd5);
    check("regdst11_rd", 32'(rd_mem), 32'd4);
    check("ctrl_mr_m2r", 32'({mem_read_mem, mem_to_reg_mem}), 32'h3);

    // SRA
    clear_inputs();
    rt_data = 32'h80000000; shamt = 5'd4; alu_op = 4'b1010;
    step();
    check("sra", alu_result_mem, 32'hF8000000);

    // SLT / SLTU with A=-1, B=1
    rs_data = 32'hFFFFFFFF; rt_data = 32'd1; alu_op = 4'b0110;
    step();
    check("slt", alu_result_mem, 32'd1);
    alu_op = 4'b0111;
    step();
    check("sltu", alu_result_mem, 32'd0);

    // LUI
    alu_src = 1'b1; imm = 32'h00001234; alu_op = 4'b1110;
    step();
    check("lui", alu_result_mem, 32'h12340000);

    // Remaining ALU codes
    clear_inputs();
    rs_data = 32'h0F0F0F24; rt_data = 32'h800000F0; shamt = 5'd4;
    for (int i = 0; i < 11; i++) begin
      alu_op = tbl_op[i];
      step();
      check($sformatf("alu_op%b", tbl_op[i]), alu_result_mem, tbl_exp[i]);
    end

    // Link with every control bit set, so the later bubble has something to clear
    clear_inputs();
    pc_plus4 = 32'h40; reg_dst = 2'b10; link = 1'b1; rs_data = 32'd7; rt_data = 32'h55; rt = 5'd3; rd = 5'd8;
    mem_read = 1'b1; mem_write = 1'b1; mem_to_reg = 1'b1; write_reg = 1'b1;
    step();
    check("link_res", alu_result_mem, 32'h44);
    check("link_rd", 32'(rd_mem), 32'd31);
    check("link_st", store_data_mem, 32'h55);

    // Stall: new inputs ignored for three cycles, flush ignored while stalled
    enable = 1'b0; link = 1'b0; rs_data = 32'd1; rt_data = 32'd2; reg_dst = 2'b01; rd = 5'd5;
    mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0; write_reg = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d_res", i), alu_result_mem, 32'h44);
    end
    check("stall_rd", 32'(rd_mem), 32'd31);
    check("stall_ctrl", 32'({mem_read_mem, mem_write_mem, mem_to_reg_mem, write_reg_mem}), 32'hF);
    flush = 1'b1;
    step();
    check("stall_flush_res", alu_result_mem, 32'h44);
    check("stall_flush_ctrl", 32'({mem_read_mem, mem_write_mem, mem_to_reg_mem, write_reg_mem}), 32'hF);

    // Bubble
    enable = 1'b1;
    step();
    check_all_zero("bubble");

    // Asynchronous reset mid-cycle after a load
    clear_inputs();
    rs_data = 32'd5; rt_data = 32'd7; reg_dst = 2'b01; rd = 5'd9; write_reg = 1'b1; mem_write = 1'b1;
    @(posedge clk);
    #2;
    check("pre_async_res", alu_result_mem, 32'd12);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    check_all_zero("async_rst_held");
    rst_n = 1'b1;
    step();
    check("post_rst_res", alu_result_mem, 32'd12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
